rx_segment_parser: RTL and testbench

Receive-side counterpart of the segment transmitter: consumes the de-framed byte stream from `rgmii_rx` in the `clk125MHz` domain and recognises one video segment per Ethernet frame. It strips preamble/SFD, MAC, EtherType and the fixed IP/UDP header, then extracts the application header (`txid`, `aux`, `segment_num`). Payload pixel bytes are written to a frame-buffer port at `segment_num*PAYLOAD_LEN + offset`. The block checks FCS and frame length and reports one status pulse per segment.

---
 rtl/rx_segment_parser.sv | 189 ++++++++++++++++++
 tb/tb_rx_segment_parser.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_segment_parser.sv
// Receive-side segment parser: strips Ethernet/IP/UDP framing, extracts the
// application header, writes payload to a frame buffer and checks FCS/length.
module rx_segment_parser #(
  parameter int          PAYLOAD_LEN = 1000,
  parameter int          HDR_SKIP    = 28,
  parameter logic [15:0] ETHERTYPE   = 16'h0800,
  parameter int          ADDR_W      = 20
) (
  input  logic              clk125MHz,
  input  logic              rstb,
  input  logic [7:0]        data,
  input  logic              data_valid,
  input  logic              data_enable,
  input  logic              data_error,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              seg_done,
  output logic              seg_crc_ok,
  output logic [7:0]        seg_txid,
  output logic [7:0]        seg_aux,
  output logic [15:0]       seg_num,
  output logic              busy,
  output logic [15:0]       good_count,
  output logic [15:0]       err_count
);

  typedef enum logic [3:0] {
    S_WAIT_GAP, S_IDLE, S_PRE, S_HDR, S_APP,
    S_PAY, S_FCS, S_TAIL, S_DROP
  } state_t;

  localparam logic [15:0] HDR_LAST = 16'(14 + HDR_SKIP - 1);
  localparam logic [15:0] PAY_LAST = 16'(PAYLOAD_LEN - 1);
  localparam logic [31:0] CRC_RES  = 32'hDEBB20E3;

  state_t              r_state;
  logic [15:0]         r_cnt;
  logic [31:0]         r_crc;
  logic [7:0]          r_eth_hi;
  logic [7:0]          r_txid;
  logic [7:0]          r_aux;
  logic [7:0]          r_num_hi;
  logic [15:0]         r_num;
  logic [ADDR_W-1:0]   r_addr;

  logic                w_smp;
  logic [31:0]         w_crc_nx;
  logic [15:0]         w_num;
  logic [ADDR_W-1:0]   w_base;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] x;
    x = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_smp    = data_valid & data_enable;
  assign w_crc_nx = crc_byte(r_crc, data);
  assign w_num    = {r_num_hi, data};
  // full-width product, truncated to the buffer address space
  assign w_base   = ADDR_W'(48'(w_num) * 48'(PAYLOAD_LEN));
  assign busy     = !(r_state inside {S_IDLE, S_WAIT_GAP});

  always_ff @(posedge clk125MHz) begin
    if (rstb) begin
      r_state    <= S_WAIT_GAP;
      r_cnt      <= '0;
      r_crc      <= 32'hFFFFFFFF;
      r_eth_hi   <= '0;
      r_txid     <= '0;
      r_aux      <= '0;
      r_num_hi   <= '0;
      r_num      <= '0;
      r_addr     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      seg_done   <= 1'b0;
      seg_crc_ok <= 1'b0;
      seg_txid   <= '0;
      seg_aux    <= '0;
      seg_num    <= '0;
      good_count <= '0;
      err_count  <= '0;
    end else begin
      wr_en    <= 1'b0;
      seg_done <= 1'b0;
      case (r_state)
        S_WAIT_GAP: if (!data_valid) r_state <= S_IDLE;
        S_IDLE: begin
          if (data_valid && data_error) begin
            r_state <= S_DROP;
          end else if (w_smp) begin
            r_cnt   <= 16'd1;
            r_state <= (data == 8'h55) ? S_PRE : S_DROP;
          end
        end
        S_DROP: begin
          if (!data_valid) begin
            err_count <= sat_inc(err_count);
            r_state   <= S_IDLE;
          end
        end
        S_TAIL: begin
          if (!data_valid) begin
            seg_done   <= 1'b1;
            seg_crc_ok <= (r_crc == CRC_RES);
            seg_txid   <= r_txid;
            seg_aux    <= r_aux;
            seg_num    <= r_num;
            if (r_crc == CRC_RES) good_count <= sat_inc(good_count);
            else                  err_count  <= sat_inc(err_count);
            r_state <= S_IDLE;
          end else if (data_error || w_smp) begin
            r_state <= S_DROP;
          end
        end
        default: begin
          // short frame: valid fell before the FCS was complete
          if (!data_valid) begin
            err_count <= sat_inc(err_count);
            r_state   <= S_IDLE;
          end else if (data_error) begin
            r_state <= S_DROP;
          end else if (w_smp) begin
            r_cnt <= r_cnt + 16'd1;
            if (r_state != S_PRE) r_crc <= w_crc_nx;
            case (r_state)
              S_PRE: begin
                if (data == 8'hD5) begin
                  r_crc   <= 32'hFFFFFFFF;
                  r_cnt   <= '0;
                  r_state <= S_HDR;
                end else if (data != 8'h55 || r_cnt == 16'd7) begin
                  r_state <= S_DROP;
                end
              end
              S_HDR: begin
                if (r_cnt == 16'd12) r_eth_hi <= data;
                if (r_cnt == 16'd13 && {r_eth_hi, data} != ETHERTYPE) begin
                  r_state <= S_DROP;
                end else if (r_cnt == HDR_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_APP;
                end
              end
              S_APP: begin
                case (r_cnt[1:0])
                  2'd0: r_txid   <= data;
                  2'd1: r_aux    <= data;
                  2'd2: r_num_hi <= data;
                  default: begin
                    r_num   <= w_num;
                    r_addr  <= w_base;
                    r_cnt   <= '0;
                    r_state <= S_PAY;
                  end
                endcase
              end
              S_PAY: begin
                wr_en   <= 1'b1;
                wr_addr <= r_addr;
                wr_data <= data;
                r_addr  <= r_addr + 1'b1;
                if (r_cnt == PAY_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_FCS;
                end
              end
              S_FCS: if (r_cnt == 16'd3) r_state <= S_TAIL;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_segment_parser.sv
// Bench for rx_segment_parser: frame-level model builds expected writes and
// segment status from the byte stream it sends; a negedge monitor compares.
module tb_rx_segment_parser;

  localparam int PL = 16;
  localparam int P0 = 54;
  localparam int PE = P0 + PL;

  typedef struct packed {
    logic [19:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct packed {
    logic [7:0]  txid;
    logic [7:0]  aux;
    logic [15:0] num;
    logic        ok;
  } seg_t;

  logic        clk;
  logic        rstb;
  logic [7:0]  data;
  logic        data_valid;
  logic        data_enable;
  logic        data_error;
  logic        wr_en;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;
  logic        seg_done;
  logic        seg_crc_ok;
  logic [7:0]  seg_txid;
  logic [7:0]  seg_aux;
  logic [15:0] seg_num;
  logic        busy;
  logic [15:0] good_count;
  logic [15:0] err_count;

  rx_segment_parser #(.PAYLOAD_LEN(PL)) dut (
    .clk125MHz(clk), .rstb(rstb), .data(data),
    .data_valid(data_valid), .data_enable(data_enable),
    .data_error(data_error), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .seg_done(seg_done), .seg_crc_ok(seg_crc_ok),
    .seg_txid(seg_txid), .seg_aux(seg_aux), .seg_num(seg_num),
    .busy(busy), .good_count(good_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  frm[$];
  wr_t         exp_w[$];
  seg_t        exp_s[$];
  logic [19:0] obs_addr[$];
  int          m_good = 0;
  int          m_err = 0;
  seg_t        m_seg = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input int a, input int b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = a; i <= b; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int j = 0; j < 8; j++)
        c = (c >> 1) ^ (32'hEDB88320 & {32{c[0]}});
    end
    return ~c;
  endfunction

  task automatic build(input logic [7:0] txid, input logic [7:0] aux,
                       input logic [15:0] num, input logic [15:0] et,
                       input int flip);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < 7; i++) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 0; i < 6; i++) frm.push_back(8'(8'h10 + i));
    for (int i = 0; i < 6; i++) frm.push_back(8'(8'h20 + i));
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    for (int i = 0; i < 28; i++) frm.push_back(8'(8'h45 + i));
    frm.push_back(txid);
    frm.push_back(aux);
    frm.push_back(num[15:8]);
    frm.push_back(num[7:0]);
    for (int k = 0; k < PL; k++) frm.push_back(8'(k));
    c = crc32(8, PE - 1);
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
    if (flip >= 0) frm[P0 + flip] = frm[P0 + flip] ^ 8'hFF;
  endtask

  // Expected outcome of sending frm[0..len-1], with an RX error or a
  // reset landing on the given byte index (-1 = none).
  task automatic model(input int err_at, input int len, input int rst_at);
    int          stop;
    logic        etok;
    logic [15:0] num;
    wr_t         w;
    seg_t        s;
    stop = len;
    if (err_at >= 0 && err_at < stop) stop = err_at;
    if (rst_at >= 0 && rst_at < stop) stop = rst_at;
    etok = ({frm[20], frm[21]} == 16'h0800);
    num  = {frm[52], frm[53]};
    if (etok)
      for (int k = 0; k < PL; k++)
        if (P0 + k < stop) begin
          w.a = 20'((int'(num) * PL + k) % (1 << 20));
          w.d = frm[P0 + k];
          exp_w.push_back(w);
        end
    if (rst_at >= 0) begin
      m_good = 0;
      m_err  = 0;
      m_seg  = '0;
    end else if (etok && err_at < 0 && len == frm.size()) begin
      s.txid = frm[50];
      s.aux  = frm[51];
      s.num  = num;
      s.ok   = (crc32(8, PE - 1) ==
                {frm[PE + 3], frm[PE + 2], frm[PE + 1], frm[PE]});
      exp_s.push_back(s);
      m_seg = s;
      if (s.ok) m_good++;
      else m_err++;
    end else begin
      m_err++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int per, input int err_at, input int len,
                       input int rst_at, input int gap);
    for (int i = 0; i < len; i++) begin
      data        = frm[i];
      data_valid  = 1'b1;
      data_enable = 1'b1;
      data_error  = (i == err_at);
      rstb        = (i == rst_at);
      tick();
      for (int g = 1; g < per; g++) begin
        data_enable = 1'b0;
        data_error  = 1'b0;
        rstb        = 1'b0;
        tick();
      end
    end
    rstb       = 1'b0;
    data_error = 1'b0;
    if (rst_at >= 0)
      for (int h = 0; h < 50; h++) begin
        data        = 8'h55;
        data_enable = 1'b1;
        tick();
        if (h == 25) chk("busy_after_rst", 32'(busy), 0);
      end
    data_valid  = 1'b0;
    data_enable = 1'b0;
    for (int g = 0; g < gap; g++) tick();
  endtask

  task automatic settle(input string nm);
    chk({nm, "_wr_left"}, exp_w.size(), 0);
    chk({nm, "_seg_left"}, exp_s.size(), 0);
    chk({nm, "_good"}, 32'(good_count), m_good);
    chk({nm, "_err"}, 32'(err_count), m_err);
    chk({nm, "_num"}, 32'(seg_num), 32'(m_seg.num));
    chk({nm, "_busy"}, 32'(busy), 0);
    exp_w.delete();
    exp_s.delete();
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      obs_addr.push_back(wr_addr);
      chk("wr_expected", 32'(exp_w.size() != 0), 1);
      if (exp_w.size() != 0) begin
        wr_t w;
        w = exp_w.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(w.a));
        chk("wr_data", 32'(wr_data), 32'(w.d));
      end
    end
    if (seg_done) begin
      chk("seg_expected", 32'(exp_s.size() != 0), 1);
      if (exp_s.size() != 0) begin
        seg_t s;
        s = exp_s.pop_front();
        chk("seg_crc_ok", 32'(seg_crc_ok), 32'(s.ok));
        chk("seg_txid", 32'(seg_txid), 32'(s.txid));
        chk("seg_aux", 32'(seg_aux), 32'(s.aux));
        chk("seg_num", 32'(seg_num), 32'(s.num));
      end
    end
  end

  initial begin
    int base;
    rstb        = 1'b1;
    data        = 8'h00;
    data_valid  = 1'b0;
    data_enable = 1'b0;
    data_error  = 1'b0;
    repeat (3) tick();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_seg_done", 32'(seg_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_good", 32'(good_count), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_seg_num", 32'(seg_num), 0);
    rstb = 1'b0;
    repeat (2) tick();

    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("crc_pin", crc32(0, 8), 32'hCBF43926);

    build(8'h03, 8'h01, 16'h0005, 16'h0800, -1);
    model(-1, 61, 60);
    drive(1, -1, 61, 60, 6);
    settle("rst_abort");
    build(8'h03, 8'h01, 16'h0005, 16'h0800, -1);
    model(-1, 74, -1);
    drive(1, -1, 74, -1, 6);
    settle("after_rst");

    rstb = 1'b1;
    tick();
    rstb = 1'b0;
    m_good = 0;
    m_err  = 0;
    m_seg  = '0;
    repeat (2) tick();

    build(8'h03, 8'h01, 16'h0005, 16'h0800, -1);
    base = obs_addr.size();
    model(-1, 74, -1);
    drive(1, -1, 74, -1, 6);
    settle("good_1g");
    chk("good_first_addr", 32'(obs_addr[base]), 32'd80);
    chk("good_n_writes", obs_addr.size() - base, 16);
    chk("good_count_lit", 32'(good_count), 1);
    chk("good_crc_lit", 32'(seg_crc_ok), 1);
    chk("good_num_lit", 32'(seg_num), 5);

    build(8'h03, 8'h01, 16'h0005, 16'h0800, 3);
    base = obs_addr.size();
    model(-1, 74, -1);
    drive(1, -1, 74, -1, 6);
    settle("flip");
    chk("flip_n_writes", obs_addr.size() - base, 16);
    chk("flip_crc_lit", 32'(seg_crc_ok), 0);
    chk("flip_err_lit", 32'(err_count), 1);

    build(8'h03, 8'h01, 16'h0005, 16'h0800, -1);
    model(-1, 74, -1);
    drive(10, -1, 74, -1, 6);
    settle("good_100m");

    build(8'h03, 8'h01, 16'h0005, 16'h86DD, -1);
    base = obs_addr.size();
    model(-1, 74, -1);
    drive(1, -1, 74, -1, 6);
    settle("ethertype");
    chk("eth_n_writes", obs_addr.size() - base, 0);

    build(8'h03, 8'h01, 16'h0005, 16'h0800, -1);
    base = obs_addr.size();
    model(-1, P0 + 10, -1);
    drive(1, -1, P0 + 10, -1, 6);
    settle("trunc");
    chk("trunc_n_writes", obs_addr.size() - base, 10);

    build(8'h07, 8'h02, 16'h0009, 16'h0800, -1);
    base = obs_addr.size();
    model(P0 + 5, 74, -1);
    drive(1, P0 + 5, 74, -1, 6);
    settle("rxerr");
    chk("rxerr_n_writes", obs_addr.size() - base, 5);

    build(8'h08, 8'h03, 16'h000A, 16'h0800, -1);
    model(-1, 74, -1);
    drive(1, -1, 74, -1, 1);
    build(8'h09, 8'h04, 16'h000B, 16'h0800, -1);
    model(-1, 74, -1);
    drive(1, -1, 74, -1, 6);
    settle("b2b");
    chk("b2b_aux", 32'(seg_aux), 32'h04);

    build(8'h0A, 8'h05, 16'hFFFF, 16'h0800, -1);
    base = obs_addr.size();
    model(-1, 74, -1);
    drive(10, -1, 74, -1, 6);
    settle("wrap");
    chk("wrap_first_addr", 32'(obs_addr[base]), 32'h000FFFF0);
    chk("wrap_last_addr", 32'(obs_addr[base + 15]), 32'h000FFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
